alu_issue_ctrl: RTL and testbench

Sequencing and arbitration front-end for the shared 32-bit combinational ALU. Two requesters submit opcode/operand pairs over valid/ready handshakes. The block arbitrates round-robin and registers the winning operands onto the ALU inputs. It holds them stable for an opcode-dependent number of cycles so the slow multiply and divide paths settle, then returns the captured result to the granted requester over a valid/ready response channel.

---
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue front-end for a shared combinational ALU: round-robin arbitration of two
// requesters, operand hold for opcode-dependent latency, and per-requester response.
module alu_issue_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [3:0]  req1_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  output logic        resp0_valid,
  output logic        resp1_valid,
  input  logic        resp0_ready,
  input  logic        resp1_ready,
  output logic [31:0] resp0_data,
  output logic [31:0] resp1_data,
  output logic        resp0_err,
  output logic        resp1_err,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_data0,
  output logic [31:0] alu_data1,
  input  logic [31:0] alu_out,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the holder keeps payload stable until then.

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_L + 1);

  state_t        state;
  logic          grant;
  logic          prio;
  logic [CW-1:0] cnt;
  logic [31:0]   result;
  logic          err;

  logic          any_valid;
  logic          pick;
  logic [3:0]    sel_opcode;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;
  logic          sel_unmapped;
  logic          done;

  function automatic logic [CW-1:0] lat_m1(input logic [3:0] op);
    case (op)
      4'd2:    lat_m1 = CW'(MUL_CYCLES - 1);
      4'd3:    lat_m1 = CW'(DIV_CYCLES - 1);
      default: lat_m1 = '0;
    endcase
  endfunction

  always_comb begin
    any_valid    = req0_valid | req1_valid;
    pick         = (req0_valid && req1_valid) ? prio : req1_valid;
    sel_opcode   = pick ? req1_opcode : req0_opcode;
    sel_a        = pick ? req1_a : req0_a;
    sel_b        = pick ? req1_b : req0_b;
    sel_unmapped = (sel_opcode == 4'd7) || (sel_opcode == 4'd15);
    done         = (state == RESP) && (grant ? resp1_ready : resp0_ready);
  end

  // Ready is gated by reset so it reads 0 while reset_n is held low.
  assign req0_ready  = reset_n && (state == IDLE) && any_valid && !pick;
  assign req1_ready  = reset_n && (state == IDLE) && any_valid && pick;
  assign resp0_valid = (state == RESP) && !grant;
  assign resp1_valid = (state == RESP) && grant;
  assign resp0_data  = resp0_valid ? result : 32'd0;
  assign resp1_data  = resp1_valid ? result : 32'd0;
  assign resp0_err   = resp0_valid && err;
  assign resp1_err   = resp1_valid && err;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      prio       <= 1'b0;
      cnt        <= '0;
      result     <= 32'd0;
      err        <= 1'b0;
      alu_opcode <= 4'd0;
      alu_data0  <= 32'd0;
      alu_data1  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_opcode <= sel_opcode;
            alu_data0  <= sel_a;
            alu_data1  <= sel_b;
            grant      <= pick;
            cnt        <= lat_m1(sel_opcode);
            if (sel_unmapped) begin
              result <= 32'd0;
              err    <= 1'b1;
              state  <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            result <= alu_out;
            err    <= 1'b0;
            state  <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (done) begin
            state <= IDLE;
            prio  <= ~grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the bench plays the ALU, and a transaction-level
// model (in-flight op + response timestamp) is compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode = 4'd0, req1_opcode = 4'd0;
  logic [31:0] req0_a = 32'd0, req1_a = 32'd0, req0_b = 32'd0, req1_b = 32'd0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_err, resp1_err;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_data0, alu_data1, alu_out;
  logic        busy;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad = 0;

  alu_issue_ctrl #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp0_data(resp0_data), .resp1_data(resp1_data),
    .resp0_err(resp0_err), .resp1_err(resp1_err),
    .alu_opcode(alu_opcode), .alu_data0(alu_data0), .alu_data1(alu_data1),
    .alu_out(alu_out), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  alu_fn = a + b;
      4'd1:  alu_fn = a - b;
      4'd2:  alu_fn = a * b;
      4'd3:  alu_fn = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd4:  alu_fn = {31'd0, a == b};
      4'd5:  alu_fn = {31'd0, a < b};
      4'd6:  alu_fn = {31'd0, $signed(a) < $signed(b)};
      4'd8:  alu_fn = a & b;
      4'd9:  alu_fn = a | b;
      4'd10: alu_fn = a ^ b;
      4'd11: alu_fn = ~(a ^ b);
      4'd12: alu_fn = a << b[4:0];
      4'd13: alu_fn = a >> b[4:0];
      4'd14: alu_fn = $signed(a) >>> b[4:0];
      default: alu_fn = 32'd0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_opcode, alu_data0, alu_data1);

  function automatic int lat(input logic [3:0] op);
    if (op == 4'd2) return MUL_L;
    if (op == 4'd3) return DIV_L;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: one op in flight, response visible from a cycle stamp.
  int          cyc = 0;
  bit          m_busy = 0, m_who = 0, m_prio = 0, m_err = 0;
  int          m_resp_cyc = 0;
  logic [31:0] m_data = 0, m_a = 0, m_b = 0;
  logic [3:0]  m_op = 0;
  bit          any, w, e_r0, e_r1, e_v0, e_v1, unm;
  logic [3:0]  n_op;
  logic [31:0] n_a, n_b;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_busy = 0; m_prio = 0; m_op = 0; m_a = 0; m_b = 0;
    end
    any  = req0_valid | req1_valid;
    w    = (req0_valid && req1_valid) ? m_prio : req1_valid;
    e_r0 = reset_n && !m_busy && any && !w;
    e_r1 = reset_n && !m_busy && any && w;
    e_v0 = m_busy && (cyc >= m_resp_cyc) && !m_who;
    e_v1 = m_busy && (cyc >= m_resp_cyc) && m_who;
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("resp0_valid", resp0_valid, e_v0);
    chk("resp1_valid", resp1_valid, e_v1);
    chk("resp0_data", resp0_data, e_v0 ? m_data : 32'd0);
    chk("resp1_data", resp1_data, e_v1 ? m_data : 32'd0);
    chk("resp0_err", resp0_err, e_v0 && m_err);
    chk("resp1_err", resp1_err, e_v1 && m_err);
    chk("alu_opcode", alu_opcode, m_op);
    chk("alu_data0", alu_data0, m_a);
    chk("alu_data1", alu_data1, m_b);
    chk("busy", busy, m_busy);
    if (reset_n) begin
      if ((e_v0 && resp0_ready) || (e_v1 && resp1_ready)) begin
        m_busy = 0;
        m_prio = ~m_who;
      end else if (e_r0 || e_r1) begin
        n_op = w ? req1_opcode : req0_opcode;
        n_a  = w ? req1_a : req0_a;
        n_b  = w ? req1_b : req0_b;
        unm  = (n_op == 4'd7) || (n_op == 4'd15);
        m_busy = 1; m_who = w; m_op = n_op; m_a = n_a; m_b = n_b;
        m_err  = unm;
        m_data = unm ? 32'd0 : alu_fn(n_op, n_a, n_b);
        m_resp_cyc = unm ? cyc + 1 : cyc + 1 + lat(n_op);
      end
    end
  end

  task automatic drive(input bit id, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic wait_ready(input bit id, output bit ok);
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat, input int hold);
    int n;
    bit ok;
    @(posedge clk); #1;
    if (hold > 0) begin
      if (id) resp1_ready = 1'b0; else resp0_ready = 1'b0;
    end
    drive(id, 1'b1, op, a, b);
    wait_ready(id, ok);
    @(posedge clk); #1;
    drive(id, 1'b0, op, a, b);
    if (!ok) return;
    n = 0;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (id ? resp1_valid : resp0_valid) begin
        ok = 1;
        break;
      end
      n++;
    end
    if (!ok) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", n, exp_lat);
    chk("data", id ? resp1_data : resp0_data, exp_data);
    chk("err", id ? resp1_err : resp0_err, exp_err);
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", id ? resp1_valid : resp0_valid, 1);
      chk("hold_data", id ? resp1_data : resp0_data, exp_data);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      if (id) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after", busy, 0);
  endtask

  task automatic contend(input int n, input bit first);
    bit exp_id, ok, got;
    exp_id = first;
    got = 0;
    @(posedge clk); #1;
    drive(0, 1'b1, 4'd0, 32'd10, 32'd1);
    drive(1, 1'b1, 4'd0, 32'd20, 32'd2);
    for (int g = 0; g < n; g++) begin
      ok = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          ok = 1;
          got = req1_ready;
          break;
        end
      end
      if (!ok) begin
        chk("grant_timeout", 32'd0, 32'd1);
        break;
      end
      chk("grant_order", got, exp_id);
      @(posedge clk); #1;
      drive(got, 1'b1, 4'd0, 32'd100 + 32'(g), 32'd3 + 32'(g));
      exp_id = ~exp_id;
    end
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_alu", {28'd0, alu_opcode} | alu_data0 | alu_data1, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    issue(0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1, 0);
    issue(1, 4'd2, 32'd6, 32'd7, 32'd42, 1'b0, MUL_L, 0);
    issue(1, 4'd14, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 0);
    contend(4, 1'b0);
    issue(0, 4'd15, 32'd123, 32'd456, 32'd0, 1'b1, 0, 0);
    issue(0, 4'd7, 32'd9, 32'd9, 32'd0, 1'b1, 0, 0);
    issue(0, 4'd1, 32'd10, 32'd3, 32'd7, 1'b0, 1, 5);
    issue(0, 4'd3, 32'd100, 32'd7, 32'd14, 1'b0, DIV_L, 0);

    // Divide on req1 with priority at 1, reset 5 cycles into EXEC.
    @(posedge clk); #1;
    drive(1, 1'b1, 4'd3, 32'd100, 32'd7);
    wait_ready(1, ok);
    @(posedge clk); #1;
    drive(1, 1'b0, 4'd3, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {27'd0, resp0_valid, resp1_valid, req0_ready, req1_ready, busy}, 0);
    chk("rst_mid_alu", {28'd0, alu_opcode} | alu_data0 | alu_data1, 0);
    chk("rst_mid_resp", resp0_data | resp1_data | {31'd0, resp0_err | resp1_err}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("no_stale_resp", resp1_valid, 0);
    end
    contend(2, 1'b0);
    issue(1, 4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
